flappy_bird_motion: RTL and testbench
=====================================

# flappy_bird_motion

Parametrised bird-motion controller for the Flappy game core. Holds the bird's X/Y screen position and a signed vertical velocity. On each frame tick it applies gravity with a terminal-velocity clamp, a flap impulse with press/release debouncing, and ceiling/floor bounds. It enters a lost state on floor contact or an external collision. It sits between the button synchroniser and the VGA renderer / pipe-collision logic.

## Interface
- `W`, 10: width of the X/Y coordinates (unsigned, screen Y grows downward).
- `VW`, 6: width of the velocity register (signed two's complement).
- `X_START`, 144: X reset/init position, constant during play.
- `Y_START`, 320: Y reset/init position.
- `Y_MIN`, 0: ceiling Y.
- `Y_MAX`, 464: floor Y (bird bottom on ground).
- `GRAV`, 1: velocity increment per tick.
- `FLAP_VEL`, 8: flap speed; velocity is set to −FLAP_VEL.
- `V_MAX`, 12: terminal (downward) velocity.
- `FLAP_TICKS`, 4: ticks spent in FLAP before re-arm is possible.
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Tick` in 1: one-cycle frame strobe (physics enable).
- `Start` in 1: start game from I.
- `Ack` in 1: acknowledge loss, return to I.
- `Flap_Button` in 1: synchronised, level-sensitive flap button.
- `Hit` in 1: external collision (pipe), level.
- `XBird` out W: bird X.
- `YBird` out W: bird Y.
- `VelY` out VW: signed vertical velocity (+ = down).
- `q_I`, `q_Flap`, `q_Unpress`, `q_Grav`, `q_Lost` out 1 each: one-hot state outputs.

## Operation
- Reset (`Reset_n` low, async): state I, `XBird`=X_START, `YBird`=Y_START, `VelY`=0, flap counter 0.
- I: force X/Y to start values, `VelY`=0. `Start`=1 goes to FLAP with `VelY`=−FLAP_VEL and counter 0.
- Physics, in FLAP/UNPRESS/GRAV on `Tick`=1 only:
  - sum = `YBird` + `VelY`, computed signed in W+2 bits.
  - sum ≤ Y_MIN: `YBird`=Y_MIN and `VelY`=0 (ceiling bump, no loss).
  - sum ≥ Y_MAX: `YBird`=Y_MAX, `VelY`=0, go LOST.
  - Otherwise `YBird`=sum, then `VelY`=min(`VelY`+GRAV, V_MAX).
- FLAP:
  - Each `Tick` increments the counter.
  - On the tick where counter = FLAP_TICKS−1, go UNPRESS.
  - Button presses in FLAP are ignored.
- UNPRESS: `Flap_Button`=0 goes to GRAV. Holding the button never re-flaps.
- GRAV: `Flap_Button`=1 goes to FLAP, `VelY`=−FLAP_VEL, counter 0. This is not Tick-gated; it takes effect the next cycle.
- Flap on the same cycle as a `Tick`: the new velocity wins. The position update for that tick uses the old `VelY`.
- `Hit`=1 in FLAP/UNPRESS/GRAV goes to LOST on any cycle, not Tick-gated. Position and velocity freeze.
- Priority: `Hit` > floor > flap.
- LOST: outputs frozen. `Ack`=1 goes to I, and I reloads the start values the next cycle.
- Illegal state encodings recover to I.
- `XBird` is always X_START.

## Timing
- All registered outputs are updated on the rising `Clk` edge.
- State one-hot outputs are registered with zero extra latency: the state bit changes on the edge that samples the cause.
- Position changes only on Tick cycles. Start→first movement occurs at the first `Tick` after entering FLAP.
- Ack, Start and button changes are sampled every cycle. Pulse widths ≥ 1 cycle are sufficient.
- A `Reset_n` assertion mid-play clears everything immediately. Release is synchronised externally.

## Test plan
- Reset, then `Start` pulse, then 3 Ticks, button released, defaults → `YBird` 320→312→305→299, `VelY` −8→−7→−6→−5; q_Flap held.
- Button held from Start through FLAP_TICKS=4 ticks → q_Unpress; it stays there while held. Release → q_Grav. Press → q_Flap with `VelY`=−8.
- Free fall from Y=320, no presses → `VelY` saturates at 12 and never exceeds it. `YBird` reaches 464, then q_Lost with `VelY`=0. `Ack` → q_I with Y=320.
- Repeated flaps near the top with Y_START=10 → `YBird` clamps at 0, `VelY`=0, no q_Lost.
- `Hit` asserted mid-GRAV on the same cycle as a button press and a Tick → q_Lost next cycle; Y/Vel unchanged from the prior cycle.
- `Reset_n` pulsed low mid-FLAP, asynchronously between edges → outputs return to I/start values immediately. Then Start works normally.

Source files
------------

// File: rtl/flappy_bird_motion_if.sv
// Control strobes into the bird-motion block and its position/velocity/state outputs.
// master = game control side driving the strobes, slave = the motion block.
interface flappy_bird_motion_if #(
  parameter int W  = 10,
  parameter int VW = 6
);
  logic                 Tick;
  logic                 Start;
  logic                 Ack;
  logic                 Flap_Button;
  logic                 Hit;
  logic [W-1:0]         XBird;
  logic [W-1:0]         YBird;
  logic signed [VW-1:0] VelY;
  logic                 q_I;
  logic                 q_Flap;
  logic                 q_Unpress;
  logic                 q_Grav;
  logic                 q_Lost;

  modport master (
    output Tick, Start, Ack, Flap_Button, Hit,
    input  XBird, YBird, VelY, q_I, q_Flap, q_Unpress, q_Grav, q_Lost
  );

  modport slave (
    input  Tick, Start, Ack, Flap_Button, Hit,
    output XBird, YBird, VelY, q_I, q_Flap, q_Unpress, q_Grav, q_Lost
  );
endinterface

// File: rtl/flappy_bird_motion.sv
// Bird motion: gravity with terminal clamp, debounced flap, ceiling/floor bounds, loss on floor or Hit.
// State and position are registered; transitions land on the edge that samples their cause.
module flappy_bird_motion #(
  parameter int W          = 10,
  parameter int VW         = 6,
  parameter int X_START    = 144,
  parameter int Y_START    = 320,
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 464,
  parameter int GRAV       = 1,
  parameter int FLAP_VEL   = 8,
  parameter int V_MAX      = 12,
  parameter int FLAP_TICKS = 4
) (
  input logic                 Clk,
  input logic                 Reset_n,
  flappy_bird_motion_if.slave bus
);

  localparam int SW = W + 2;
  localparam int CW = $clog2(FLAP_TICKS + 1);
  localparam logic signed [VW-1:0] VEL_FLAP = VW'(-FLAP_VEL);

  typedef enum logic [4:0] {
    S_I       = 5'b00001,
    S_FLAP    = 5'b00010,
    S_UNPRESS = 5'b00100,
    S_GRAV    = 5'b01000,
    S_LOST    = 5'b10000
  } state_t;

  state_t               state;
  logic [W-1:0]         y;
  logic signed [VW-1:0] vel;
  logic [CW-1:0]        cnt;

  logic signed [SW-1:0] sum;
  logic signed [VW:0]   vel_inc;
  logic                 ceil_hit;
  logic                 floor_hit;
  logic [W-1:0]         y_phys;
  logic signed [VW-1:0] vel_phys;

  // One physics step; sum is signed and two bits wider so an upward move past 0 stays negative.
  always_comb begin
    sum       = $signed({2'b00, y}) + $signed({{(SW-VW){vel[VW-1]}}, vel});
    vel_inc   = $signed({vel[VW-1], vel}) + $signed((VW+1)'(GRAV));
    ceil_hit  = (sum <= $signed(SW'(Y_MIN)));
    floor_hit = (sum >= $signed(SW'(Y_MAX)));
    y_phys    = sum[W-1:0];
    vel_phys  = vel_inc[VW-1:0];
    if (ceil_hit) begin
      y_phys   = W'(Y_MIN);
      vel_phys = '0;
    end else if (floor_hit) begin
      y_phys   = W'(Y_MAX);
      vel_phys = '0;
    end else if (vel_inc > $signed((VW+1)'(V_MAX))) begin
      vel_phys = VW'(V_MAX);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_I;
      y     <= W'(Y_START);
      vel   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_I: begin
          y   <= W'(Y_START);
          vel <= '0;
          cnt <= '0;
          if (bus.Start) begin
            state <= S_FLAP;
            vel   <= VEL_FLAP;
          end
        end
        S_FLAP, S_UNPRESS, S_GRAV: begin
          if (bus.Hit) begin
            state <= S_LOST;
          end else if (bus.Tick && floor_hit) begin
            state <= S_LOST;
            y     <= W'(Y_MAX);
            vel   <= '0;
          end else begin
            if (bus.Tick) begin
              y   <= y_phys;
              vel <= vel_phys;
            end
            if (state == S_FLAP && bus.Tick) begin
              cnt <= cnt + CW'(1);
              if (cnt == CW'(FLAP_TICKS - 1))
                state <= S_UNPRESS;
            end
            if (state == S_UNPRESS && !bus.Flap_Button)
              state <= S_GRAV;
            // A flap overrides the velocity the same-cycle tick would have written.
            if (state == S_GRAV && bus.Flap_Button) begin
              state <= S_FLAP;
              vel   <= VEL_FLAP;
              cnt   <= '0;
            end
          end
        end
        S_LOST: begin
          if (bus.Ack)
            state <= S_I;
        end
        default: state <= S_I;
      endcase
    end
  end

  assign bus.XBird     = W'(X_START);
  assign bus.YBird     = y;
  assign bus.VelY      = vel;
  assign bus.q_I       = state[0];
  assign bus.q_Flap    = state[1];
  assign bus.q_Unpress = state[2];
  assign bus.q_Grav    = state[3];
  assign bus.q_Lost    = state[4];

endmodule

// File: tb/tb_flappy_bird_motion.sv
// Directed bench for flappy_bird_motion: expected Y/Vel/state pushed per driven cycle, popped after the edge.
module tb_flappy_bird_motion;

  localparam logic [4:0] QI = 5'b00001;
  localparam logic [4:0] QF = 5'b00010;
  localparam logic [4:0] QU = 5'b00100;
  localparam logic [4:0] QG = 5'b01000;
  localparam logic [4:0] QL = 5'b10000;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  flappy_bird_motion_if #(.W(10), .VW(6)) b1 ();
  flappy_bird_motion_if #(.W(10), .VW(6)) b2 ();

  flappy_bird_motion u1 (.Clk(Clk), .Reset_n(Reset_n), .bus(b1));
  flappy_bird_motion #(.Y_START(10)) u2 (.Clk(Clk), .Reset_n(Reset_n), .bus(b2));

  logic [4:0] q1, q2;
  assign q1 = {b1.q_Lost, b1.q_Grav, b1.q_Unpress, b1.q_Flap, b1.q_I};
  assign q2 = {b2.q_Lost, b2.q_Grav, b2.q_Unpress, b2.q_Flap, b2.q_I};

  typedef struct {
    string             tag;
    logic [9:0]        y;
    logic signed [5:0] v;
    logic [4:0]        q;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push_exp(input string tag, input int y, input int v, input logic [4:0] q);
    exp_t e;
    e.tag = tag;
    e.y   = 10'(y);
    e.v   = 6'(v);
    e.q   = q;
    sbq.push_back(e);
  endtask

  task automatic check_dut(input logic [9:0] x, input logic [9:0] y,
                           input logic signed [5:0] v, input logic [4:0] q);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: got nothing queued, want one entry");
      return;
    end
    e = sbq.pop_front();
    n_cmp++;
    assert (x === 10'd144) else begin
      n_err++;
      $error("FAIL %s XBird: got %0d want %0d", e.tag, x, 144);
    end
    n_cmp++;
    assert (y === e.y) else begin
      n_err++;
      $error("FAIL %s YBird: got %0d want %0d", e.tag, y, e.y);
    end
    n_cmp++;
    assert (v === e.v) else begin
      n_err++;
      $error("FAIL %s VelY: got %0d want %0d", e.tag, v, e.v);
    end
    n_cmp++;
    assert (q === e.q) else begin
      n_err++;
      $error("FAIL %s state: got %b want %b", e.tag, q, e.q);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One cycle on DUT1: drive strobes (button is a level and is held), queue expectation, clock, compare.
  task automatic cyc1(input logic tick, input logic start, input logic ack, input logic btn,
                      input logic hit, input string tag, input int y, input int v,
                      input logic [4:0] q);
    b1.Tick = tick; b1.Start = start; b1.Ack = ack; b1.Flap_Button = btn; b1.Hit = hit;
    push_exp(tag, y, v, q);
    step();
    b1.Tick = 1'b0; b1.Start = 1'b0; b1.Ack = 1'b0; b1.Hit = 1'b0;
    check_dut(b1.XBird, b1.YBird, b1.VelY, q1);
  endtask

  task automatic cyc2(input logic tick, input logic start, input logic btn,
                      input string tag, input int y, input int v, input logic [4:0] q);
    b2.Tick = tick; b2.Start = start; b2.Flap_Button = btn;
    push_exp(tag, y, v, q);
    step();
    b2.Tick = 1'b0; b2.Start = 1'b0;
    check_dut(b2.XBird, b2.YBird, b2.VelY, q2);
  endtask

  initial begin
    int my, mv, s, k;
    bit lost;
    logic [4:0] mq;

    b1.Tick = 0; b1.Start = 0; b1.Ack = 0; b1.Flap_Button = 0; b1.Hit = 0;
    b2.Tick = 0; b2.Start = 0; b2.Ack = 0; b2.Flap_Button = 0; b2.Hit = 0;
    Reset_n = 1'b0;
    #12;
    push_exp("reset1", 320, 0, QI);
    check_dut(b1.XBird, b1.YBird, b1.VelY, q1);
    push_exp("reset2", 10, 0, QI);
    check_dut(b2.XBird, b2.YBird, b2.VelY, q2);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Start and first three ticks with the button released.
    cyc1(0, 1, 0, 0, 0, "start",  320, -8, QF);
    cyc1(1, 0, 0, 0, 0, "tick1",  312, -7, QF);
    cyc1(1, 0, 0, 0, 0, "tick2",  305, -6, QF);
    cyc1(1, 0, 0, 0, 0, "tick3",  299, -5, QF);
    cyc1(1, 0, 0, 0, 0, "tick4",  294, -4, QU);
    cyc1(0, 0, 0, 0, 0, "rel",    294, -4, QG);

    // Flap, then hold the button through the whole FLAP window and beyond.
    cyc1(0, 0, 0, 1, 0, "flap",   294, -8, QF);
    cyc1(1, 0, 0, 1, 0, "htick1", 286, -7, QF);
    cyc1(1, 0, 0, 1, 0, "htick2", 279, -6, QF);
    cyc1(1, 0, 0, 1, 0, "htick3", 273, -5, QF);
    cyc1(1, 0, 0, 1, 0, "htick4", 268, -4, QU);
    cyc1(0, 0, 0, 1, 0, "hold1",  268, -4, QU);
    cyc1(0, 0, 0, 1, 0, "hold2",  268, -4, QU);
    cyc1(0, 0, 0, 0, 0, "hrel",   268, -4, QG);
    cyc1(0, 0, 0, 1, 0, "reflap", 268, -8, QF);
    cyc1(1, 0, 0, 0, 0, "ftick1", 260, -7, QF);
    cyc1(1, 0, 0, 0, 0, "ftick2", 253, -6, QF);
    cyc1(1, 0, 0, 0, 0, "ftick3", 247, -5, QF);
    cyc1(1, 0, 0, 0, 0, "ftick4", 242, -4, QU);
    cyc1(0, 0, 0, 0, 0, "tograv", 242, -4, QG);

    // Hit together with a press and a tick: loss wins, position/velocity freeze.
    cyc1(1, 0, 0, 1, 1, "hit",    242, -4, QL);
    cyc1(1, 0, 0, 0, 0, "frozen", 242, -4, QL);
    cyc1(0, 0, 1, 0, 0, "ack",    242, -4, QI);
    cyc1(0, 0, 0, 0, 0, "reload", 320,  0, QI);

    // Free fall against an independent integer model until the floor.
    cyc1(0, 1, 0, 0, 0, "fstart", 320, -8, QF);
    my = 320; mv = -8; k = 0; lost = 0;
    while (!lost && k < 100) begin
      k++;
      s = my + mv;
      if (s <= 0) begin
        my = 0; mv = 0;
      end else if (s >= 464) begin
        my = 464; mv = 0; lost = 1;
      end else begin
        my = s;
        mv = (mv + 1 > 12) ? 12 : mv + 1;
      end
      mq = lost ? QL : (k < 4 ? QF : (k == 4 ? QU : QG));
      cyc1(1, 0, 0, 0, 0, "fall", my, mv, mq);
      n_cmp++;
      assert (b1.VelY <= 6'sd12) else begin
        n_err++;
        $error("FAIL fall_vmax: got %0d want <= 12", b1.VelY);
      end
    end
    cyc1(0, 0, 1, 0, 0, "fack",    464, 0, QI);
    cyc1(0, 0, 0, 0, 0, "freload", 320, 0, QI);

    // Ceiling clamp on the Y_START=10 instance, with a repeat flap.
    cyc2(0, 1, 0, "c_start", 10, -8, QF);
    cyc2(1, 0, 0, "c_t1",     2, -7, QF);
    cyc2(1, 0, 0, "c_t2",     0,  0, QF);
    cyc2(1, 0, 0, "c_t3",     0,  0, QF);
    cyc2(1, 0, 0, "c_t4",     0,  0, QU);
    cyc2(0, 0, 0, "c_rel",    0,  0, QG);
    cyc2(0, 0, 1, "c_flap",   0, -8, QF);
    cyc2(1, 0, 0, "c_t5",     0,  0, QF);

    // Asynchronous reset mid-FLAP, observed between edges.
    cyc1(0, 1, 0, 0, 0, "r_start", 320, -8, QF);
    cyc1(1, 0, 0, 0, 0, "r_tick",  312, -7, QF);
    #2;
    Reset_n = 1'b0;
    #1;
    push_exp("midreset", 320, 0, QI);
    check_dut(b1.XBird, b1.YBird, b1.VelY, q1);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc1(0, 1, 0, 0, 0, "p_start", 320, -8, QF);
    cyc1(1, 0, 0, 0, 0, "p_tick",  312, -7, QF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
